// File: rtl/rom_arb.sv
// Two-port (fetch / data) read arbiter in front of a single-cycle ROM.
// Define ROM_ARB_RR_EN for round-robin conflicts; default is fixed mem priority.
module rom_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        mem_req_i,
   input  logic [31:0] mem_addr_i,
   output logic        mem_gnt_o,
   output logic        mem_rvalid_o,
   output logic [31:0] mem_rdata_o,
   input  logic        flush_i,
   output logic        rom_ce_o,
   output logic [31:0] rom_addr_o,
   input  logic [31:0] rom_data_i
);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

   owner_t owner_p1;
   owner_t owner_d;
   logic   if_ok;
   logic   conflict;
   logic   mem_wins;
   logic   if_gnt;
   logic   mem_gnt;

   // request stage (p0): combinational arbitration and ROM drive
   always_comb begin
      if_ok    = if_req_i & ~flush_i & ~rst;
      conflict = if_ok & mem_req_i;
      mem_gnt  = mem_req_i & ~rst & (~if_ok | mem_wins);
      if_gnt   = if_ok & ~mem_gnt;
   end

`ifdef ROM_ARB_RR_EN
   // Set means the data port is preferred on the next conflict.
   logic mem_pref_p1;

   always_ff @(posedge clk) begin
      if (rst)
         mem_pref_p1 <= 1'b0;
      else if (conflict)
         mem_pref_p1 <= if_gnt;
   end

   assign mem_wins = mem_pref_p1;
`else
   assign mem_wins = 1'b1;
`endif

   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt)
         owner_d = OWN_IF;
      else if (mem_gnt)
         owner_d = OWN_MEM;
   end

   always_comb begin
      if_gnt_o   = if_gnt;
      mem_gnt_o  = mem_gnt;
      rom_ce_o   = if_gnt | mem_gnt;
      rom_addr_o = 32'h0;
      if (if_gnt)
         rom_addr_o = if_addr_i;
      else if (mem_gnt)
         rom_addr_o = mem_addr_i;
   end

   // response stage (p1): owner of the ROM word arriving this cycle
   always_ff @(posedge clk) begin
      if (rst)
         owner_p1 <= OWN_NONE;
      else
         owner_p1 <= owner_d;
   end

   always_comb begin
      if_rvalid_o  = (owner_p1 == OWN_IF) & ~flush_i & ~rst;
      mem_rvalid_o = (owner_p1 == OWN_MEM) & ~rst;
      if_rdata_o   = if_rvalid_o  ? rom_data_i : 32'h0;
      mem_rdata_o  = mem_rvalid_o ? rom_data_i : 32'h0;
   end

endmodule

// File: tb/tb_rom_arb.sv
// Bench for rom_arb: directed scenarios then random traffic against a
// transaction-level model (grant decision + one pending response).
module tb_rom_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        mem_req_i;
   logic [31:0] mem_addr_i;
   logic        mem_gnt_o;
   logic        mem_rvalid_o;
   logic [31:0] mem_rdata_o;
   logic        flush_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_data_i;

   int n_assert = 0;
   int n_fail   = 0;

   rom_arb dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i), .mem_gnt_o(mem_gnt_o),
      .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
      .flush_i(flush_i), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
      .rom_data_i(rom_data_i)
   );

   always #5 clk = ~clk;

   // ROM: word one cycle after enable, garbage otherwise
   logic [31:0] rom [64];
   always @(posedge clk) begin
      if (rom_ce_o === 1'b1)
         rom_data_i <= rom[rom_addr_o[7:2]];
      else
         rom_data_i <= $urandom;
   end

   // reference model: 0 none, 1 fetch, 2 data
   int          pend_port = 0;
   logic [31:0] pend_data = 32'h0;
   bit          m_mem_pref = 1'b0;

   // what the last step observed
   logic        obs_ig, obs_mg, obs_iv, obs_mv, obs_ce;
   logic [31:0] obs_ir, obs_mr, obs_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic ireq, input logic [31:0] iaddr,
                       input logic mreq, input logic [31:0] maddr, input logic fl);
      bit          e_ig, e_mg, e_iv, e_mv, if_elig, mem_first;
      logic [31:0] e_addr;
      @(negedge clk);
      rst = r; if_req_i = ireq; if_addr_i = iaddr;
      mem_req_i = mreq; mem_addr_i = maddr; flush_i = fl;
      #1;
      if_elig = !r && ireq && !fl;
`ifdef ROM_ARB_RR_EN
      mem_first = m_mem_pref;
`else
      mem_first = 1'b1;
`endif
      e_mg = !r && mreq && (!if_elig || mem_first);
      e_ig = if_elig && !e_mg;
      e_addr = e_ig ? iaddr : (e_mg ? maddr : 32'h0);
      e_iv = !r && !fl && pend_port == 1;
      e_mv = !r && pend_port == 2;
      obs_ig = if_gnt_o; obs_mg = mem_gnt_o; obs_iv = if_rvalid_o; obs_mv = mem_rvalid_o;
      obs_ce = rom_ce_o; obs_addr = rom_addr_o; obs_ir = if_rdata_o; obs_mr = mem_rdata_o;
      chk("if_gnt",     {31'b0, if_gnt_o},     {31'b0, e_ig});
      chk("mem_gnt",    {31'b0, mem_gnt_o},    {31'b0, e_mg});
      chk("rom_ce",     {31'b0, rom_ce_o},     {31'b0, e_ig | e_mg});
      chk("rom_addr",   rom_addr_o,            e_addr);
      chk("if_rvalid",  {31'b0, if_rvalid_o},  {31'b0, e_iv});
      chk("mem_rvalid", {31'b0, mem_rvalid_o}, {31'b0, e_mv});
      chk("if_rdata",   if_rdata_o,            e_iv ? pend_data : 32'h0);
      chk("mem_rdata",  mem_rdata_o,           e_mv ? pend_data : 32'h0);
      @(posedge clk);
      if (r) begin
         pend_port = 0; m_mem_pref = 1'b0;
      end else begin
         if (if_elig && mreq) m_mem_pref = e_ig;
         pend_port = e_ig ? 1 : (e_mg ? 2 : 0);
         pend_data = rom[e_addr[7:2]];
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      logic        ir, mr, fl, r;
      logic [31:0] ia, ma;
      logic [1:0]  seq [4];
      for (int i = 0; i < 64; i++) rom[i] = $urandom;
      rom[4] = 32'h00500093;
      rst = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0; mem_req_i = 1'b0;
      mem_addr_i = 32'h0; flush_i = 1'b0; rom_data_i = 32'h0;

      // reset with requests pending: nothing granted, nothing valid
      step(1'b1, 1'b1, 32'h10, 1'b1, 32'h40, 1'b0);
      chk("rst_ce", {31'b0, obs_ce}, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      idle();
      chk("post_rst_valid", {30'b0, obs_iv, obs_mv}, 32'h0);

      // single fetch
      step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
      chk("fetch_gnt", {31'b0, obs_ig}, 32'h1);
      idle();
      chk("fetch_data", obs_ir, 32'h00500093);

`ifndef ROM_ARB_RR_EN
      // fixed priority conflict: data port first
      step(1'b0, 1'b1, 32'h14, 1'b1, 32'h40, 1'b0);
      chk("conf_mem_gnt", {31'b0, obs_mg}, 32'h1);
      chk("conf_addr", obs_addr, 32'h40);
      step(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
      chk("conf_if_gnt", {30'b0, obs_ig, obs_mv}, 32'h3);
      idle();
      chk("conf_if_valid", {31'b0, obs_iv}, 32'h1);
`else
      // round-robin: both held four cycles alternate starting with fetch
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 32'h14, 1'b1, 32'h40, 1'b0);
         seq[i] = {obs_mg, obs_ig};
      end
      chk("rr_seq", {24'b0, seq[0], seq[1], seq[2], seq[3]}, 32'h66);
      idle();
      chk("rr_last_valid", {31'b0, obs_mv}, 32'h1);
`endif

      // flush kills fetch response, data port still granted
      step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1);
      chk("flush_iv_mg", {30'b0, obs_iv, obs_mg}, 32'h1);
      idle();
      chk("flush_mv", {31'b0, obs_mv}, 32'h1);

      // reset mid-transaction
      step(1'b0, 1'b1, 32'h24, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h28, 1'b0, 32'h0, 1'b0);
      chk("midrst_v1", {29'b0, obs_iv, obs_mv, obs_ce}, 32'h0);
      idle();
      chk("midrst_v2", {30'b0, obs_iv, obs_mv}, 32'h0);

      // back-to-back fetch stream
      step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
      chk("b2b_0", obs_ir, rom[0]);
      step(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
      chk("b2b_1", obs_ir, rom[1]);
      idle();
      chk("b2b_2", obs_ir, rom[2]);

      // random traffic, requests held until granted
      ir = 1'b0; mr = 1'b0; ia = 32'h0; ma = 32'h0;
      obs_ig = 1'b1; obs_mg = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (!ir || obs_ig) begin
            ir = ($urandom_range(0, 2) != 0);
            ia = {24'b0, 6'($urandom), 2'b00};
         end
         if (!mr || obs_mg) begin
            mr = ($urandom_range(0, 2) != 0);
            ma = {24'b0, 6'($urandom), 2'b00};
         end
         fl = ($urandom_range(0, 7) == 0);
         r  = ($urandom_range(0, 40) == 0);
         step(r, ir, ia, mr, ma, fl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
